// File: rtl/sp_ram_stream_reader_pkg.sv
// Shared definitions for the single-port RAM stream reader: FSM state
// encodings, default geometry and the RAM read latency.
package sp_ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Issue-to-push distance: address register stage plus synchronous RAM stage.
  localparam int RD_LAT = 2;

endpackage

// File: rtl/sp_ram_rd_fifo.sv
// Small synchronous show-ahead FIFO buffering RAM words (plus a last tag)
// between the read pipeline and the output stream.
module sp_ram_rd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sp_ram_stream_reader.sv
// Read sequencer: sweeps a wrap-around RAM address range on start and
// streams the words out over valid/ready with full backpressure.
module sp_ram_stream_reader
  import sp_ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_adr,
  output logic                  ram_wre,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = $clog2(FIFO_DEPTH + RD_LAT + 1);

  state_t                state;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH-1:0] next_adr;
  logic [RD_LAT-1:0]     vld_pipe;
  logic [RD_LAT-1:0]     last_pipe;
  logic [SW-1:0]         inflight;
  logic [FCW-1:0]        fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  credit_ok;
  logic                  issue;
  logic                  issue_last;
  logic                  pop;
  logic                  sweep_done;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + SW'(vld_pipe[i]);
  end

  // Words already buffered plus words still in the RAM pipeline must leave
  // room for one more, so the FIFO can never be overrun.
  assign credit_ok  = (SW'(fifo_count) + inflight) < SW'(FIFO_DEPTH);
  assign issue      = (state == READ) && credit_ok;
  assign issue_last = (issue_cnt == count_q - 1'b1);
  assign pop        = out_valid && out_ready;
  assign sweep_done = (state == DRAIN) && pop && fifo_head[DATA_WIDTH]
                      && (inflight == '0) && (fifo_count == FCW'(1));

  assign ram_wre   = 1'b0;
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_head[DATA_WIDTH-1:0];
  assign out_last  = out_valid && fifo_head[DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_adr   <= '0;
      count_q   <= '0;
      issue_cnt <= '0;
      next_adr  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              count_q   <= count;
              next_adr  <= base;
              issue_cnt <= '0;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            ram_adr   <= next_adr;
            next_adr  <= next_adr + 1'b1;
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt + 1'b1 == count_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish on the edge that accepts the tagged last word.
          if (sweep_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[RD_LAT-2:0], issue};
      last_pipe <= {last_pipe[RD_LAT-2:0], issue && issue_last};
    end
  end

  sp_ram_rd_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (vld_pipe[RD_LAT-1]),
    .push_data({last_pipe[RD_LAT-1], ram_q}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_sp_ram_stream_reader.sv
// Bench for sp_ram_stream_reader: a behavioural RAM plus a queue-based
// model of the expected word stream, driven with seeded random backpressure.
module tb_sp_ram_stream_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] base;
  logic [4:0] count;
  logic       busy;
  logic       done;
  logic [3:0] ram_adr;
  logic       ram_wre;
  logic [7:0] ram_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  logic [7:0] mem [16];
  logic [8:0] expQ [$];

  int   errorCount = 0;
  int   checkCount = 0;
  int   cycle = 0;
  int   xferCount = 0;
  int   firstXferNeg = -1;
  int   lastXferNeg = -100;
  int   doneCount = 0;
  int   doneNeg = -1;
  int   maxOcc = 0;
  logic busyAtDone = 1'b0;
  bit   prevStall = 0;
  logic [8:0] prevWord = '0;
  bit   readyRandom = 0;
  logic readyHold = 1'b1;

  sp_ram_stream_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .ram_adr  (ram_adr),
    .ram_wre  (ram_wre),
    .ram_q    (ram_q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  // Synchronous-read RAM: data appears the cycle after the address is sampled.
  always @(posedge clk) ram_q <= mem[ram_adr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Scoreboard and stream-protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [8:0] expWord;
    if (rst) begin
      prevStall = 0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_word", 32'({out_last, out_data}), 32'(prevWord));
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_word", 32'(expQ.size()), 32'd1);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("word", 32'({out_last, out_data}), 32'(expWord));
          if (expWord[8]) lastXferNeg = cycle;
        end
        if (xferCount == 0) firstXferNeg = cycle;
        xferCount++;
      end
      if (done) begin
        doneCount++;
        doneNeg = cycle;
        busyAtDone = busy;
      end
      if (int'(dut.fifo_count) > maxOcc) maxOcc = int'(dut.fifo_count);
      prevStall = out_valid && !out_ready;
      prevWord = {out_last, out_data};
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (readyRandom) out_ready = ($urandom_range(0, 1) == 1);
      else out_ready = readyHold;
    end
  end

  // Raise start for one cycle; the model queue gets the words the sweep should produce.
  task automatic applyStimulus(input logic [3:0] b, input logic [4:0] c, input bit expectAccept);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = b;
    count = c;
    xferCount = 0;
    if (expectAccept) begin
      for (int i = 0; i < int'(c); i++) begin
        expQ.push_back({(i == int'(c) - 1), mem[(int'(b) + i) % 16]});
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, input bit timingCheck);
    int startDone = doneCount;
    int n = 0;
    while (doneCount == startDone && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(doneCount != startDone), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_pulses", 32'(doneCount - startDone), 32'd1);
    checkOutput("model_drained", 32'(expQ.size()), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    if (timingCheck) begin
      checkOutput("done_timing", 32'(doneNeg), 32'(lastXferNeg + 1));
      checkOutput("busy_with_done", 32'(busyAtDone), 32'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_adr"}, 32'(ram_adr), 32'd0);
    checkOutput({tag, "_wre"}, 32'(ram_wre), 32'd0);
    checkOutput({tag, "_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    int n;
    int doneBefore;
    logic [3:0] adrBefore;
    logic [3:0] rb;
    logic [4:0] rc;

    void'($urandom(32'd20240611));
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    rst = 1'b1;
    start = 1'b0;
    base = '0;
    count = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] sweep base=0 count=8, ready high");
    readyRandom = 0;
    readyHold = 1'b1;
    applyStimulus(4'd0, 5'd8, 1);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("no_early_valid0", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("first_adr", 32'(ram_adr), 32'd0);
    checkOutput("no_early_valid1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("no_early_valid2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("valid_at_edge3", 32'(out_valid), 32'd1);
    checkOutput("first_data", 32'(out_data), 32'hA0);
    waitDone(60, 1);
    checkOutput("throughput", 32'(lastXferNeg - firstXferNeg), 32'd7);
    checkOutput("xfer_total", 32'(xferCount), 32'd8);

    $display("[TB] wrap sweep base=14 count=4");
    applyStimulus(4'd14, 5'd4, 1);
    @(posedge clk);
    #1;
    checkOutput("wrap_adr0", 32'(ram_adr), 32'd14);
    @(posedge clk);
    #1;
    checkOutput("wrap_adr1", 32'(ram_adr), 32'd15);
    @(posedge clk);
    #1;
    checkOutput("wrap_adr2", 32'(ram_adr), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("wrap_adr3", 32'(ram_adr), 32'd1);
    waitDone(60, 1);

    $display("[TB] full sweep count=16 with random backpressure");
    readyRandom = 1;
    maxOcc = 0;
    applyStimulus(4'($urandom_range(0, 15)), 5'd16, 1);
    waitDone(600, 1);
    checkOutput("fifo_bound", 32'(maxOcc <= 4), 32'd1);
    checkOutput("full_xfers", 32'(xferCount), 32'd16);

    $display("[TB] zero-length start");
    readyRandom = 0;
    adrBefore = ram_adr;
    doneBefore = doneCount;
    applyStimulus(4'd5, 5'd0, 1);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("zero_done_pulse", 32'(done), 32'd0);
    checkOutput("zero_busy2", 32'(busy), 32'd0);
    checkOutput("zero_valid", 32'(out_valid), 32'd0);
    checkOutput("zero_adr", 32'(ram_adr), 32'(adrBefore));
    checkOutput("zero_done_count", 32'(doneCount - doneBefore), 32'd1);

    $display("[TB] start pulsed mid-sweep is ignored");
    applyStimulus(4'd9, 5'd8, 1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    base = 4'd3;
    count = 5'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(80, 1);
    checkOutput("mid_start_xfers", 32'(xferCount), 32'd8);

    $display("[TB] random sweeps");
    readyRandom = 1;
    for (int k = 0; k < 6; k++) begin
      rb = 4'($urandom_range(0, 15));
      rc = 5'($urandom_range(1, 16));
      maxOcc = 0;
      applyStimulus(rb, rc, 1);
      waitDone(600, 1);
      checkOutput("rand_bound", 32'(maxOcc <= 4), 32'd1);
    end

    $display("[TB] reset mid-sweep");
    readyRandom = 0;
    readyHold = 1'b1;
    applyStimulus(4'd0, 5'd8, 1);
    n = 0;
    while (xferCount < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkOutput("three_words", 32'(xferCount >= 3), 32'd1);
    #2;
    rst = 1'b1;
    doneBefore = doneCount;
    #1;
    checkAllZero("midrst");
    expQ.delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_done_on_rst", 32'(doneCount - doneBefore), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd0, 5'd2, 1);
    waitDone(60, 1);
    checkOutput("post_rst_xfers", 32'(xferCount), 32'd2);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
